pulse_sync_mc: RTL

Multi-channel, single-clock receive-side event synchroniser. Each channel samples an asynchronous toggle or level signal from a foreign domain through a SYNC_STAGES-deep flop chain and detects edges according to EDGE_MODE. It emits a stretched strobe per detected event and keeps a saturating, acknowledgeable event count per channel. It sits at the destination of every cross-domain event path, replacing per-signal ad hoc synchronisers.

---
 rtl/pulse_sync_mc_if.sv | 24 ++
 rtl/pulse_sync_mc.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pulse_sync_mc_if.sv
// Bundles the per-channel event inputs and status outputs of pulse_sync_mc.
// The master side drives events and acknowledges; the slave side is the synchroniser.
interface pulse_sync_mc_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 4
) ();
  logic [CH-1:0]       async_in;
  logic [CH-1:0]       evt_ack;
  logic [CH-1:0]       ovf_clr;
  logic [CH-1:0]       pulse_out;
  logic [CH-1:0]       evt_pend;
  logic [CH*CNT_W-1:0] evt_cnt;
  logic [CH-1:0]       overflow;

  modport master (
    output async_in, evt_ack, ovf_clr,
    input  pulse_out, evt_pend, evt_cnt, overflow
  );

  modport slave (
    input  async_in, evt_ack, ovf_clr,
    output pulse_out, evt_pend, evt_cnt, overflow
  );
endinterface

// File: rtl/pulse_sync_mc.sv
// Multi-channel receive-side event synchroniser: sync chain, edge detect, pulse
// stretcher and a saturating acknowledgeable event counter per channel.
module pulse_sync_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int STRETCH     = 1,
  parameter int CNT_W       = 4
) (
  input logic            clk,
  input logic            rst,
  pulse_sync_mc_if.slave bus
);
  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [SW-1:0]    STR_LOAD = SW'(STRETCH);
  localparam logic [SW-1:0]    STR_ONE  = SW'(1);
  localparam logic [SW-1:0]    STR_ZERO = {SW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [SYNC_STAGES-1:0] sync_r [CH];
  logic [CH-1:0]          hist_r;
  logic [CH-1:0]          detect_s;
  logic [SW-1:0]          str_r [CH];
  logic [SW-1:0]          str_nxt_s [CH];
  logic [CNT_W-1:0]       cnt_r [CH];
  logic [CNT_W-1:0]       cnt_nxt_s [CH];
  logic [CH-1:0]          ovf_r;
  logic [CH-1:0]          ovf_nxt_s;
  logic [CH-1:0]          ovf_set_s;
  logic [CH-1:0]          pulse_r;
  logic [CH-1:0]          pend_r;

  function automatic logic edge_detect(input logic cur, input logic prev);
    logic res;
    case (EDGE_MODE)
      32'sd1:  res = cur & ~prev;
      32'sd2:  res = ~cur & prev;
      default: res = cur ^ prev;
    endcase
    return res;
  endfunction

  // Synchroniser chains plus the history flop that follows the last stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        sync_r[i] <= {SYNC_STAGES{1'b0}};
      end
      hist_r <= {CH{1'b0}};
    end else begin
      for (int i = 0; i < CH; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], bus.async_in[i]};
        hist_r[i] <= sync_r[i][SYNC_STAGES-1];
      end
    end
  end

  // Next-state for edge detect, stretcher, event count and sticky overflow
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      detect_s[i]  = edge_detect(sync_r[i][SYNC_STAGES-1], hist_r[i]);
      str_nxt_s[i] = str_r[i];
      cnt_nxt_s[i] = cnt_r[i];
      ovf_set_s[i] = 1'b0;
      ovf_nxt_s[i] = ovf_r[i];

      // A new detect always reloads, so back-to-back events merge into one strobe
      if (detect_s[i]) begin
        str_nxt_s[i] = STR_LOAD;
      end else if (str_r[i] != STR_ZERO) begin
        str_nxt_s[i] = str_r[i] - STR_ONE;
      end else begin
        str_nxt_s[i] = str_r[i];
      end

      if (detect_s[i] && !bus.evt_ack[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          ovf_set_s[i] = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else if (detect_s[i] && bus.evt_ack[i]) begin
        // Ack of an empty counter is ignored, so the new event still lands
        if (cnt_r[i] == CNT_ZERO) begin
          cnt_nxt_s[i] = CNT_ONE;
        end else begin
          cnt_nxt_s[i] = cnt_r[i];
        end
      end else if (bus.evt_ack[i] && (cnt_r[i] != CNT_ZERO)) begin
        cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end

      if (ovf_set_s[i]) begin
        ovf_nxt_s[i] = 1'b1;
      end else if (bus.ovf_clr[i]) begin
        ovf_nxt_s[i] = 1'b0;
      end else begin
        ovf_nxt_s[i] = ovf_r[i];
      end
    end
  end

  // Per-channel state registers; strobe and pending flags track the next-state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        str_r[i] <= STR_ZERO;
        cnt_r[i] <= CNT_ZERO;
      end
      ovf_r   <= {CH{1'b0}};
      pulse_r <= {CH{1'b0}};
      pend_r  <= {CH{1'b0}};
    end else begin
      for (int i = 0; i < CH; i++) begin
        str_r[i]   <= str_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
        pulse_r[i] <= (str_nxt_s[i] != STR_ZERO);
        pend_r[i]  <= (cnt_nxt_s[i] != CNT_ZERO);
      end
      ovf_r <= ovf_nxt_s;
    end
  end

  // Pack the per-channel counts onto the flat status bus
  always_comb begin
    bus.evt_cnt = {(CH*CNT_W){1'b0}};
    for (int i = 0; i < CH; i++) begin
      bus.evt_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
    end
  end

  assign bus.pulse_out = pulse_r;
  assign bus.evt_pend  = pend_r;
  assign bus.overflow  = ovf_r;
endmodule
